// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg
//   Shared constants and types for the data-cache controller.
//   Cache geometry (tag / set-index / block size) must match the
//   Dcache_SRAM array that the controller drives.
//   Also holds the controller FSM state encoding and the lane-select width.
package dcache_ctrl_pkg;

  // Cache geometry: 2 sets of 8-byte blocks with 32-bit CPU addresses.
  localparam int DTAG_SIZE        = 28;
  localparam int DSET_INDEX_SIZE  = 1;
  localparam int DBLOCK_SIZE      = 8;
  localparam int DBLOCK_SIZE_BITS = 8 * DBLOCK_SIZE;

  // A block is split into 32-bit word lanes; this is the lane-select width.
  localparam int WORD_BYTES = 4;
  localparam int LANE_SEL_W = $clog2(DBLOCK_SIZE / WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_REFILL = 2'd2,
    ST_REPLAY = 2'd3
  } dc_state_e;

  // Word 0 sits in the most-significant lane, so lane position counts down.
  function automatic int lane_pos(input int lanes, input int word);
    return lanes - 1 - word;
  endfunction

endpackage

// File: rtl/dcache_perf_counters.sv
// dcache_perf_counters
//   Free-running 32-bit event counters for the data-cache controller.
//   They wrap at 2^32 and clear on the synchronous active-high reset.
//   Ports:
//     clk, rst               clock and synchronous active-high reset
//     inc_hit_i              one-cycle pulse: hit seen in IDLE
//     inc_miss_i             one-cycle pulse: miss seen in IDLE
//     inc_wb_i               one-cycle pulse: write-back completed
//     hits_o, misses_o, wbs_o  counter values
module dcache_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_hit_i,
  input  logic        inc_miss_i,
  input  logic        inc_wb_i,
  output logic [31:0] hits_o,
  output logic [31:0] misses_o,
  output logic [31:0] wbs_o
);

  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;
  logic [31:0] wbs_q, wbs_d;

  // Next-count logic; additions wrap naturally at 32 bits.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    wbs_d    = wbs_q;
    if (inc_hit_i) begin
      hits_d = hits_q + 32'd1;
    end else begin
      hits_d = hits_q;
    end
    if (inc_miss_i) begin
      misses_d = misses_q + 32'd1;
    end else begin
      misses_d = misses_q;
    end
    if (inc_wb_i) begin
      wbs_d = wbs_q + 32'd1;
    end else begin
      wbs_d = wbs_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= 32'd0;
      misses_q <= 32'd0;
      wbs_q    <= 32'd0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbs_q    <= wbs_d;
    end
  end

  assign hits_o   = hits_q;
  assign misses_o = misses_q;
  assign wbs_o    = wbs_q;

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl
//   Controller for the Dcache_SRAM data array, sitting between the MEM stage
//   (32-bit loads/stores with a stall handshake) and next-level memory
//   (block-wide transfers with a one-cycle ready pulse).
//   Hits complete in the IDLE cycle. A miss writes back a dirty victim (WB),
//   refills the block (REFILL) and then replays the original access (REPLAY).
//   Ports:
//     clk, rst                          clock, synchronous active-high reset
//     cpu_ren/cpu_wen/cpu_addr/cpu_be/cpu_wdata   CPU request (store wins)
//     cpu_rdata, cpu_stall              load data and pipeline hold
//     sram_ren/wen/memWen/bytesAccess/blockAddr/dataIn   array controls
//     sram_hit/dirtyBit/dataOut/victimTag               array responses
//     mem_ren/mem_wen/mem_addr/mem_wdata                block request
//     mem_rdata, mem_ready              block data and completion pulse
//   Optional build macro DCACHE_PERF_CNT_EN adds perf_hits, perf_misses and
//   perf_writebacks counter outputs.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int TAG_W     = DTAG_SIZE,
  parameter int IDX_W     = DSET_INDEX_SIZE,
  parameter int BLK_BYTES = DBLOCK_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_ren,
  input  logic                     cpu_wen,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [3:0]               cpu_be,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_stall,
  output logic                     sram_ren,
  output logic                     sram_wen,
  output logic                     sram_memWen,
  output logic [BLK_BYTES-1:0]     sram_bytesAccess,
  output logic [TAG_W+IDX_W-1:0]   sram_blockAddr,
  output logic [8*BLK_BYTES-1:0]   sram_dataIn,
  input  logic                     sram_hit,
  input  logic                     sram_dirtyBit,
  input  logic [8*BLK_BYTES-1:0]   sram_dataOut,
  input  logic [TAG_W-1:0]         sram_victimTag,
  output logic                     mem_ren,
  output logic                     mem_wen,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [8*BLK_BYTES-1:0]   mem_wdata,
  input  logic [8*BLK_BYTES-1:0]   mem_rdata,
  input  logic                     mem_ready
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]              perf_hits,
  output logic [31:0]              perf_misses,
  output logic [31:0]              perf_writebacks
`endif
);

  localparam int BLK_BITS = 8 * BLK_BYTES;
  localparam int OFF_W    = $clog2(BLK_BYTES);
  localparam int BA_W     = TAG_W + IDX_W;
  localparam int LANES    = BLK_BYTES / WORD_BYTES;
  localparam int SEL_W    = OFF_W - 2;

  dc_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
  logic [3:0]            req_be_q, req_be_d;
  logic [31:0]           req_wdata_q, req_wdata_d;
  logic                  req_st_q, req_st_d;
  logic [BLK_BITS-1:0]   wb_buf_q, wb_buf_d;
  logic [TAG_W-1:0]      wb_tag_q, wb_tag_d;

  logic                  access_s;
  logic [ADDR_W-1:0]     sel_addr_s;
  logic [3:0]            sel_be_s;
  logic [31:0]           sel_wdata_s;
  logic                  sel_st_s;
  logic [SEL_W-1:0]      word_s;
  int                    lane_s;
  logic [BA_W-1:0]       blk_s;
  logic [IDX_W-1:0]      req_idx_s;
  logic [BLK_BYTES-1:0]  st_bytes_s;
  logic [BLK_BITS-1:0]   st_data_s;
  logic [31:0]           ld_word_s;
  logic                  unused_s;

  assign access_s = cpu_ren | cpu_wen;

  // In IDLE the live CPU request drives the array; afterwards the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      sel_addr_s  = cpu_addr;
      sel_be_s    = cpu_be;
      sel_wdata_s = cpu_wdata;
      sel_st_s    = cpu_wen;
    end else begin
      sel_addr_s  = req_addr_q;
      sel_be_s    = req_be_q;
      sel_wdata_s = req_wdata_q;
      sel_st_s    = req_st_q;
    end
  end

  assign word_s      = sel_addr_s[OFF_W-1:2];
  assign lane_s      = lane_pos(LANES, int'(word_s));
  assign blk_s       = sel_addr_s[ADDR_W-1:OFF_W];
  assign req_idx_s   = req_addr_q[OFF_W+IDX_W-1:OFF_W];
  assign st_bytes_s  = BLK_BYTES'(sel_be_s) << (WORD_BYTES * lane_s);
  assign st_data_s   = {LANES{sel_wdata_s}};
  // Byte-within-word bits are irrelevant to a word-granular cache.
  assign unused_s    = ^sel_addr_s[1:0];

  // Pick the addressed 32-bit lane out of the array's block output.
  always_comb begin
    ld_word_s = 32'd0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_s == k) begin
        ld_word_s = sram_dataOut[32*k +: 32];
      end else begin
        ld_word_s = ld_word_s;
      end
    end
  end

  // Next-state and output logic; reset forces every strobe low in the same cycle.
  always_comb begin
    state_d          = state_q;
    req_addr_d       = req_addr_q;
    req_be_d         = req_be_q;
    req_wdata_d      = req_wdata_q;
    req_st_d         = req_st_q;
    wb_buf_d         = wb_buf_q;
    wb_tag_d         = wb_tag_q;
    cpu_rdata        = 32'd0;
    cpu_stall        = 1'b0;
    sram_ren         = 1'b0;
    sram_wen         = 1'b0;
    sram_memWen      = 1'b0;
    sram_bytesAccess = {BLK_BYTES{1'b0}};
    sram_blockAddr   = {BA_W{1'b0}};
    sram_dataIn      = {BLK_BITS{1'b0}};
    mem_ren          = 1'b0;
    mem_wen          = 1'b0;
    mem_addr         = {ADDR_W{1'b0}};
    mem_wdata        = {BLK_BITS{1'b0}};

    if (rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_s) begin
            sram_ren       = ~sel_st_s;
            sram_wen       = sel_st_s;
            sram_blockAddr = blk_s;
            sram_dataIn    = st_data_s;
            if (sel_st_s) begin
              sram_bytesAccess = st_bytes_s;
            end else begin
              sram_bytesAccess = {BLK_BYTES{1'b0}};
            end
            if (sram_hit) begin
              if (sel_st_s) begin
                cpu_rdata = 32'd0;
              end else begin
                cpu_rdata = ld_word_s;
              end
            end else begin
              // Capture the victim now: the refill overwrites it in the array.
              cpu_stall   = 1'b1;
              req_addr_d  = cpu_addr;
              req_be_d    = cpu_be;
              req_wdata_d = cpu_wdata;
              req_st_d    = cpu_wen;
              wb_buf_d    = sram_dataOut;
              wb_tag_d    = sram_victimTag;
              if (sram_dirtyBit) begin
                state_d = ST_WB;
              end else begin
                state_d = ST_REFILL;
              end
            end
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_WB: begin
          cpu_stall = 1'b1;
          mem_wen   = 1'b1;
          mem_addr  = {wb_tag_q, req_idx_s, {OFF_W{1'b0}}};
          mem_wdata = wb_buf_q;
          if (mem_ready) begin
            state_d = ST_REFILL;
          end else begin
            state_d = ST_WB;
          end
        end

        ST_REFILL: begin
          cpu_stall = 1'b1;
          mem_ren   = 1'b1;
          mem_addr  = {req_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          if (mem_ready) begin
            sram_memWen      = 1'b1;
            sram_blockAddr   = blk_s;
            sram_bytesAccess = {BLK_BYTES{1'b1}};
            sram_dataIn      = mem_rdata;
            state_d          = ST_REPLAY;
          end else begin
            state_d = ST_REFILL;
          end
        end

        ST_REPLAY: begin
          // The block was just filled, so the latched access is a hit.
          sram_ren       = ~sel_st_s;
          sram_wen       = sel_st_s;
          sram_blockAddr = blk_s;
          sram_dataIn    = st_data_s;
          if (sel_st_s) begin
            sram_bytesAccess = st_bytes_s;
            cpu_rdata        = 32'd0;
          end else begin
            sram_bytesAccess = {BLK_BYTES{1'b0}};
            cpu_rdata        = ld_word_s;
          end
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, latched request and write-back buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= {ADDR_W{1'b0}};
      req_be_q    <= 4'd0;
      req_wdata_q <= 32'd0;
      req_st_q    <= 1'b0;
      wb_buf_q    <= {BLK_BITS{1'b0}};
      wb_tag_q    <= {TAG_W{1'b0}};
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_be_q    <= req_be_d;
      req_wdata_q <= req_wdata_d;
      req_st_q    <= req_st_d;
      wb_buf_q    <= wb_buf_d;
      wb_tag_q    <= wb_tag_d;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic inc_hit_s, inc_miss_s, inc_wb_s;

  assign inc_hit_s  = ~rst & (state_q == ST_IDLE) & access_s & sram_hit;
  assign inc_miss_s = ~rst & (state_q == ST_IDLE) & access_s & ~sram_hit;
  assign inc_wb_s   = ~rst & (state_q == ST_WB) & mem_ready;

  dcache_perf_counters u_perf (
    .clk        (clk),
    .rst        (rst),
    .inc_hit_i  (inc_hit_s),
    .inc_miss_i (inc_miss_s),
    .inc_wb_i   (inc_wb_s),
    .hits_o     (perf_hits),
    .misses_o   (perf_misses),
    .wbs_o      (perf_writebacks)
  );
`endif

endmodule
